// File: rtl/score_timer_bcd.sv
// Game-state digit engine: goal/score/timer BCD registers, saturating score ops, per-second timer, win/lose.
// Optional SCORE_PAUSE_EN adds a pause input that freezes timer and score operations while in RUN.
module score_timer_bcd #(
  parameter logic [11:0] TIMER_START    = 12'h099,
  parameter int          FRAMES_PER_SEC = 60,
  parameter int          SIGN_FRAMES    = 30
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            startOfFrame,
  input  logic            start,
  input  logic [11:0]     goalIn,
  input  logic            opValid,
  input  logic            opSub,
  input  logic [3:0]      opValue,
`ifdef SCORE_PAUSE_EN
  input  logic            pause,
`endif
  output logic [8:0][3:0] numbersToShow,
  output logic            SignToShow,
  output logic            ShowSign,
  output logic            WIN,
  output logic            LOSE
);

  // state  | meaning
  // IDLE   | after reset, waiting for start; everything frozen
  // RUN    | round active: ops, timer countdown, win/lose evaluation
  // WON    | score reached goal; digits held until start/reset
  // LOST   | timer expired first; digits held until start/reset
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WON, S_LOST} state_t;

  localparam logic [7:0] FPS_M1  = 8'(FRAMES_PER_SEC - 1);
  localparam logic [7:0] SIGN_LD = 8'(SIGN_FRAMES);

  state_t      state_q, state_d;
  logic [11:0] goal_q, goal_d, score_q, score_d, timer_q, timer_d;
  logic [7:0]  frame_q, frame_d, sign_cnt_q, sign_cnt_d;
  logic        sign_q, sign_d, show_q, show_d, win_q, lose_q;
  logic        paused, run_active, op_ok;

`ifdef SCORE_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  function automatic logic [11:0] bcd_add(input logic [11:0] a, input logic [3:0] v);
    logic [4:0] d0, d1, d2;
    d0 = {1'b0, a[3:0]} + {1'b0, v};
    d1 = {1'b0, a[7:4]};
    d2 = {1'b0, a[11:8]};
    if (d0 > 5'd9) begin d0 = d0 - 5'd10; d1 = d1 + 5'd1; end
    if (d1 > 5'd9) begin d1 = d1 - 5'd10; d2 = d2 + 5'd1; end
    if (d2 > 5'd9) return 12'h999;
    return {d2[3:0], d1[3:0], d0[3:0]};
  endfunction

  // 5-bit digit lanes: bit 4 set after subtraction means the digit went negative
  function automatic logic [11:0] bcd_sub(input logic [11:0] a, input logic [3:0] v);
    logic [4:0] d0, d1, d2;
    d0 = {1'b0, a[3:0]} - {1'b0, v};
    d1 = {1'b0, a[7:4]};
    d2 = {1'b0, a[11:8]};
    if (d0[4]) begin d0 = d0 + 5'd10; d1 = d1 - 5'd1; end
    if (d1[4]) begin d1 = d1 + 5'd10; d2 = d2 - 5'd1; end
    if (d2[4]) return 12'h000;
    return {d2[3:0], d1[3:0], d0[3:0]};
  endfunction

  always_comb begin
    state_d    = state_q;
    goal_d     = goal_q;
    score_d    = score_q;
    timer_d    = timer_q;
    frame_d    = frame_q;
    sign_cnt_d = sign_cnt_q;
    sign_d     = sign_q;
    show_d     = show_q;
    run_active = (state_q == S_RUN) && !paused;
    op_ok      = opValid && run_active && (opValue <= 4'd9);

    if (start) begin
      state_d    = S_RUN;
      goal_d     = goalIn;
      score_d    = 12'h000;
      timer_d    = TIMER_START;
      frame_d    = 8'd0;
      sign_cnt_d = 8'd0;
      show_d     = 1'b0;
    end else begin
      if (op_ok)
        score_d = opSub ? bcd_sub(score_q, opValue) : bcd_add(score_q, opValue);

      if (run_active && startOfFrame) begin
        if (frame_q == FPS_M1) begin
          frame_d = 8'd0;
          timer_d = bcd_sub(timer_q, 4'd1);
        end else begin
          frame_d = frame_q + 8'd1;
        end
      end

      if (op_ok) begin
        sign_d     = opSub;
        show_d     = 1'b1;
        sign_cnt_d = SIGN_LD;
      end else if (startOfFrame && show_q) begin
        sign_cnt_d = sign_cnt_q - 8'd1;
        if (sign_cnt_q == 8'd1) show_d = 1'b0;
      end

      // win wins a tie with timer expiry
      if (state_q == S_RUN) begin
        if (score_q == goal_q)       state_d = S_WON;
        else if (timer_q == 12'h000) state_d = S_LOST;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      goal_q     <= 12'h000;
      score_q    <= 12'h000;
      timer_q    <= 12'h000;
      frame_q    <= 8'd0;
      sign_cnt_q <= 8'd0;
      sign_q     <= 1'b0;
      show_q     <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      goal_q     <= goal_d;
      score_q    <= score_d;
      timer_q    <= timer_d;
      frame_q    <= frame_d;
      sign_cnt_q <= sign_cnt_d;
      sign_q     <= sign_d;
      show_q     <= show_d;
      win_q      <= (state_d == S_WON);
      lose_q     <= (state_d == S_LOST);
    end
  end

  assign numbersToShow = {timer_q[3:0], timer_q[7:4], timer_q[11:8],
                          score_q[3:0], score_q[7:4], score_q[11:8],
                          goal_q[3:0],  goal_q[7:4],  goal_q[11:8]};
  assign SignToShow = sign_q;
  assign ShowSign   = show_q;
  assign WIN        = win_q;
  assign LOSE       = lose_q;

endmodule

// File: doc/score_timer_bcd.md
Name: score_timer_bcd

Overview:
- Game-state digit engine that feeds the score/goal/timer display stage with nine BCD digits, an operation sign and a win flag.
- Holds three 3-digit BCD registers: goal, score and countdown timer.
- Applies add/subtract hit events to the score with saturation, counts the timer down once per second using the VGA start-of-frame pulse, and detects win or lose.
- Sits between the game-logic/collision layer and the score display.

Parameters:
- TIMER_START, 12'h099, BCD value loaded into the timer on start. Three digits, each 0–9.
- FRAMES_PER_SEC, 60, number of startOfFrame pulses per timer decrement. Range 1–255.
- SIGN_FRAMES, 30, number of startOfFrame pulses that ShowSign stays high after an accepted operation. Range 1–255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per VGA frame.
- start  in  1  one-cycle pulse that starts or restarts a round.
- goalIn  in  12  goal as three BCD digits [11:8]=hundreds, [7:4]=tens, [3:0]=ones; sampled on accepted start.
- opValid  in  1  one-cycle pulse requesting a score operation.
- opSub  in  1  operation select with opValid: 1=subtract, 0=add.
- opValue  in  4  BCD operand 0–9 with opValid.
- numbersToShow  out  [8:0][3:0]  digits. [0..2] goal, [3..5] score, [6..8] timer. Within each group the lowest index is hundreds, then tens, then ones.
- SignToShow  out  1  sign of the last accepted operation: 1=minus, 0=plus.
- ShowSign  out  1  sign-visible window.
- WIN  out  1  high while in state WON.
- LOSE  out  1  high while in state LOST.

Behaviour:
- Reset is asynchronous, active-high.
  - All digits go to 0.
  - SignToShow, ShowSign, WIN and LOSE go to 0.
  - State goes to IDLE; frame counter and sign counter go to 0.
- States are IDLE, RUN, WON, LOST. All outputs are registered.
- start in any state:
  - Goes to RUN next cycle.
  - Loads goal←goalIn, score←000, timer←TIMER_START.
  - Clears the frame counter, ShowSign, WIN and LOSE.
  - start has priority over opValid and startOfFrame in the same cycle.
- Operations:
  - opValid is accepted only in RUN with opValue≤9. It is ignored otherwise, and an ignored op leaves the sign unchanged.
  - An accepted op at cycle t updates the score digits at t+1. Arithmetic is BCD, with decimal carry/borrow across the three digits.
  - Add saturates at 999 and subtract saturates at 000. Example: 995+7→999 and 003−5→000.
  - On an accepted op, SignToShow←opSub and ShowSign←1 at t+1, and the sign counter is loaded with SIGN_FRAMES.
- Sign window:
  - Each startOfFrame while ShowSign=1 decrements the sign counter. When the count reaches 0, ShowSign←0 on that same edge.
  - A new accepted op reloads the counter.
  - The sign counter runs in every state except during reset/start.
- Timer:
  - In RUN, each startOfFrame increments the frame counter.
  - When a pulse arrives with the counter = FRAMES_PER_SEC−1, the counter goes to 0 and the timer decrements by 1 in BCD (e.g. 100→099).
  - The timer never goes below 000.
  - The frame counter and timer are frozen in IDLE, WON and LOST.
- Win/lose, evaluated on registered values in RUN:
  - score==goal → WON next cycle, so an op that hits the goal at cycle t gives WIN=1 at t+2.
  - Otherwise timer==000 → LOST next cycle.
  - If both hold in the same cycle, win takes priority.
  - goal=000 gives a win at t+2 after start.
- WON and LOST hold all digits until the next start or reset.
- Reset asserted mid-round returns immediately to the reset values. Digits after reset read 000 for all groups, not TIMER_START.

Optional Feature:
- Macro SCORE_PAUSE_EN.
- When defined:
  - Adds input port pause (1 bit).
  - While pause=1 in RUN, startOfFrame is ignored for the timer and frame counter, and opValid is ignored.
  - Win/lose evaluation and the sign counter continue.
  - start still overrides pause.
- When not defined:
  - No pause port exists; behaviour is as above.

Test Plan:
- Reset then start with goalIn=12'h015 → next cycle: [0..2]=0,1,5; [3..5]=0,0,0; [6..8]=0,9,9; WIN=0, LOSE=0.
- In RUN with score 009, add 7 → score 016 at t+1; SignToShow=0 and ShowSign=1 at t+1; ShowSign drops after 30 startOfFrame pulses.
- Saturation: score 995 add 7 → 999; score 003 subtract 5 → 000 with SignToShow=1; opValue=4'hA → ignored, score and sign unchanged.
- Goal 015, score 008, add 7 → score 015 at t+1, WIN=1 at t+2; further ops ignored; timer frozen.
- FRAMES_PER_SEC=2, TIMER_START=12'h001 → timer 000 after 2 startOfFrame pulses, LOSE=1 next cycle; in the same run an op reaching the goal in the cycle the timer hits 000 → WIN=1, LOSE=0.
- Assert reset asynchronously mid-RUN (score 042) → all outputs 0 and state IDLE without a clock edge; with SCORE_PAUSE_EN, pause=1 for 120 frames → timer and score unchanged.
